// File: rtl/flag_gen.sv
`default_nettype none
// ============================================================================
// Module      : flag_gen
// Description : Multi-cycle ADD/SUB/ADC/AND flag producer, CHUNK bits per
//               cycle, LSB slice first; holds the {c,o,s,z} flag register.
//               Optional macro FLAG_GEN_RESULT_EN keeps a result register.
// Revision    : 1.0 - initial release
// ============================================================================
module flag_gen #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flags_we,
  input  logic [3:0]       flags_wdata,
  output logic             busy,
  output logic             done,
  output logic [3:0]       flags,
  output logic [WIDTH-1:0] result
);

  localparam int         c_n      = WIDTH / CHUNK;
  localparam int         c_cw     = (c_n > 1) ? $clog2(c_n) : 1;
  localparam logic [1:0] c_op_add = 2'b00;
  localparam logic [1:0] c_op_sub = 2'b01;
  localparam logic [1:0] c_op_adc = 2'b10;
  localparam logic [1:0] c_op_and = 2'b11;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t           r_state;
  logic [c_cw-1:0]  r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [1:0]       r_op;
  logic             r_carry;
  logic             r_zacc;
  logic             r_done;
  logic [3:0]       r_flags;

  logic [CHUNK-1:0] w_a_sl;
  logic [CHUNK-1:0] w_b_sl;
  logic [CHUNK:0]   w_sum;
  logic [CHUNK-1:0] w_slice;
  logic             w_is_and;
  logic             w_last;
  logic             w_zacc;
  logic             w_c;
  logic             w_o;

  // Operands shift right each cycle, so the active slice is always at bit 0.
  assign w_is_and = (r_op == c_op_and);
  assign w_a_sl   = r_a[CHUNK-1:0];
  assign w_b_sl   = (r_op == c_op_sub) ? ~r_b[CHUNK-1:0] : r_b[CHUNK-1:0];
  assign w_sum    = {1'b0, w_a_sl} + {1'b0, w_b_sl} + {{CHUNK{1'b0}}, r_carry};
  assign w_slice  = w_is_and ? (w_a_sl & r_b[CHUNK-1:0]) : w_sum[CHUNK-1:0];
  assign w_zacc   = r_zacc & (w_slice == '0);
  assign w_last   = (r_cnt == c_cw'(c_n - 1));
  assign w_c      = w_is_and ? 1'b0 : w_sum[CHUNK];
  // Carry into the MSB recovered as a^b^sum at that bit, then XOR carry out.
  assign w_o      = w_is_and ? 1'b0 :
                    (w_a_sl[CHUNK-1] ^ w_b_sl[CHUNK-1] ^ w_sum[CHUNK-1] ^ w_sum[CHUNK]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= c_op_add;
      r_carry <= 1'b0;
      r_zacc  <= 1'b0;
      r_done  <= 1'b0;
      r_flags <= 4'b0000;
    end else begin
      r_done <= 1'b0;
      if (flags_we) begin
        r_flags <= flags_wdata;
      end
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_RUN;
            r_a     <= a;
            r_b     <= b;
            r_op    <= op;
            r_cnt   <= '0;
            r_zacc  <= 1'b1;
            r_carry <= (op == c_op_sub) ? 1'b1 :
                       (op == c_op_adc) ? r_flags[3] : 1'b0;
          end
        end
        S_RUN: begin
          r_a     <= r_a >> CHUNK;
          r_b     <= r_b >> CHUNK;
          r_carry <= w_sum[CHUNK];
          r_zacc  <= w_zacc;
          r_cnt   <= r_cnt + 1'b1;
          if (w_last) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
            r_flags <= {w_c, w_o, w_slice[CHUNK-1], w_zacc};
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy  = (r_state == S_RUN);
  assign done  = r_done;
  assign flags = r_flags;

`ifdef FLAG_GEN_RESULT_EN
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] w_acc_next;

  assign w_acc_next = (r_acc >> CHUNK) | (WIDTH'(w_slice) << (WIDTH - CHUNK));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc    <= '0;
      r_result <= '0;
    end else if (r_state == S_RUN) begin
      r_acc <= w_acc_next;
      if (w_last) begin
        r_result <= w_acc_next;
      end
    end
  end

  assign result = r_result;
`else
  assign result = '0;
`endif

endmodule
`default_nettype wire
